// File: rtl/fetch_dbg_pkg.sv
// Shared definitions for the fetch debug sequencer: FSM state encoding,
// host command bytes, bus widths and the instruction-memory write payload.
`timescale 1ns/1ps
package fetch_dbg_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned STATE_W    = 3;
  localparam int unsigned CNT_ADDR_W = 8;

  // Encoding is visible to the host through state_o, so values are fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_LD_CNT    = 3'd1,
    ST_LD_DATA   = 3'd2,
    ST_LD_WRITE  = 3'd3,
    ST_RUN       = 3'd4,
    ST_STEP_WAIT = 3'd5,
    ST_STEP_EXEC = 3'd6
  } state_e;

  localparam logic [BYTE_W-1:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [BYTE_W-1:0] CMD_RUN   = 8'h52;  // 'R'
  localparam logic [BYTE_W-1:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [BYTE_W-1:0] CMD_NEXT  = 8'h4E;  // 'N'
  localparam logic [BYTE_W-1:0] CMD_EXIT  = 8'h45;  // 'E'
  localparam logic [BYTE_W-1:0] CMD_PAUSE = 8'h50;  // 'P'

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } imem_wr_t;

  // True when a valid received byte equals the given command.
  function automatic logic is_cmd(input logic valid, input logic [BYTE_W-1:0] b,
                                  input logic [BYTE_W-1:0] cmd);
    return valid && (b == cmd);
  endfunction

endpackage

// File: rtl/fetch_debug_sequencer_if.sv
// Host/fetch-side bus of the debug sequencer.
//  master: host side (drives rx byte stream and halt, observes everything else)
//  slave : sequencer side
`timescale 1ns/1ps
interface fetch_debug_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  import fetch_dbg_pkg::*;

  logic [BYTE_W-1:0]  rx_data;
  logic               rx_valid;
  logic               halt_detected;
  logic               load_program;
  logic               wr_instruction;
  logic [ADDR_W-1:0]  wr_addr;
  logic [WORD_W-1:0]  wr_data;
  logic               stop_debug;
  logic               load_done;
  logic               load_error;
  logic [STATE_W-1:0] state_o;
  logic [CNT_W-1:0]   cycle_count;

  modport master (
    output rx_data, rx_valid, halt_detected,
    input  load_program, wr_instruction, wr_addr, wr_data, stop_debug,
           load_done, load_error, state_o, cycle_count
  );

  modport slave (
    input  rx_data, rx_valid, halt_detected,
    output load_program, wr_instruction, wr_addr, wr_data, stop_debug,
           load_done, load_error, state_o, cycle_count
  );

endinterface

// File: rtl/word_assembler.sv
// Collects four received bytes into a little-endian 32-bit word.
//  clear       : drops any partial word (byte index back to 0)
//  byte_valid  : byte_data is taken this cycle
//  word_c      : full word including the byte presented this cycle
//  word_ready_c: this cycle's byte completes a word
`timescale 1ns/1ps
module word_assembler
  import fetch_dbg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word_c,
  output logic              word_ready_c
);

  logic [1:0]        idx_q;
  logic [WORD_W-1:0] shreg_q;

  // New bytes enter at the top so the first byte ends up in [7:0].
  assign word_c       = {byte_data, shreg_q[WORD_W-1:BYTE_W]};
  assign word_ready_c = byte_valid && !clear && (idx_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= 2'd0;
      shreg_q <= '0;
    end else if (clear) begin
      idx_q   <= 2'd0;
    end else if (byte_valid) begin
      idx_q   <= idx_q + 2'd1;
      shreg_q <= word_c;
    end
  end

endmodule

// File: rtl/fetch_debug_sequencer.sv
// Debug sequencer for the instruction-fetch stage: loads a program from the
// host byte stream into instruction memory and runs or single-steps the
// pipeline by gating the fetch stall.
//  clk, rst : system clock (posedge), async active-high reset
//  bus      : slave side of fetch_debug_sequencer_if (rx stream, halt,
//             imem write port, stall, load status pulses, state, cycle count)
`timescale 1ns/1ps
module fetch_debug_sequencer
  import fetch_dbg_pkg::*;
#(
  parameter int unsigned RX_TIMEOUT = 100000,
  parameter int unsigned CNT_W      = 32
) (
  input logic                    clk,
  input logic                    rst,
  fetch_debug_sequencer_if.slave bus
);

  localparam int unsigned     TO_W    = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RX_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [CNT_ADDR_W-1:0] word_cnt_q, addr_q;
  logic [TO_W-1:0]       idle_q;
  logic [CNT_W-1:0]      cyc_q;
  logic [WORD_W-1:0]     wr_data_q, asm_word_c;
  logic                  asm_ready_c, asm_clear_c, asm_valid_c;
  logic                  in_load_rx_c, timeout_c, last_word_c, halt_c;
  logic                  stop_d, load_prog_d, wr_d, done_d, err_d, cnt_clr_c;
  logic                  stop_q, load_prog_q, wr_q, done_q, err_q;
  imem_wr_t              wr_c;

  assign in_load_rx_c = (state_q == ST_LD_CNT) || (state_q == ST_LD_DATA);
  assign timeout_c    = (RX_TIMEOUT != 0) && in_load_rx_c && !bus.rx_valid && (idle_q == TO_LAST);
  assign last_word_c  = (addr_q + CNT_ADDR_W'(1)) == word_cnt_q;
  assign halt_c       = bus.halt_detected;

  // Bytes only feed the assembler in LD_DATA; a byte during LD_WRITE is dropped.
  assign asm_valid_c = bus.rx_valid && (state_q == ST_LD_DATA);
  assign asm_clear_c = timeout_c || (state_q != ST_LD_DATA);

  word_assembler u_word_asm (
    .clk          (clk),
    .rst          (rst),
    .clear        (asm_clear_c),
    .byte_valid   (asm_valid_c),
    .byte_data    (bus.rx_data),
    .word_c       (asm_word_c),
    .word_ready_c (asm_ready_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if      (is_cmd(bus.rx_valid, bus.rx_data, CMD_LOAD)) state_d = ST_LD_CNT;
        else if (is_cmd(bus.rx_valid, bus.rx_data, CMD_RUN))  state_d = ST_RUN;
        else if (is_cmd(bus.rx_valid, bus.rx_data, CMD_STEP)) state_d = ST_STEP_WAIT;
      end
      ST_LD_CNT: begin
        if (timeout_c)         state_d = ST_IDLE;
        else if (bus.rx_valid) state_d = (bus.rx_data == '0) ? ST_IDLE : ST_LD_DATA;
      end
      ST_LD_DATA: begin
        if (timeout_c)        state_d = ST_IDLE;
        else if (asm_ready_c) state_d = ST_LD_WRITE;
      end
      ST_LD_WRITE: state_d = last_word_c ? ST_IDLE : ST_LD_DATA;
      ST_RUN: begin
        if (halt_c || is_cmd(bus.rx_valid, bus.rx_data, CMD_PAUSE)) state_d = ST_IDLE;
      end
      ST_STEP_WAIT: begin
        if (halt_c || is_cmd(bus.rx_valid, bus.rx_data, CMD_EXIT))  state_d = ST_IDLE;
        else if (is_cmd(bus.rx_valid, bus.rx_data, CMD_NEXT))       state_d = ST_STEP_EXEC;
      end
      ST_STEP_EXEC: begin
        if (halt_c || is_cmd(bus.rx_valid, bus.rx_data, CMD_EXIT))  state_d = ST_IDLE;
        else                                                        state_d = ST_STEP_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values, derived from the transition so every output is a flop.
  always_comb begin
    stop_d      = 1'b1;
    load_prog_d = 1'b0;
    wr_d        = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_clr_c   = 1'b0;
    stop_d      = !((state_d == ST_RUN) || (state_d == ST_STEP_EXEC));
    load_prog_d = (state_d == ST_LD_CNT) || (state_d == ST_LD_DATA) || (state_d == ST_LD_WRITE);
    wr_d        = (state_d == ST_LD_WRITE);
    // LD_CNT -> IDLE without timeout means a zero word count.
    done_d      = ((state_q == ST_LD_CNT) && (state_d == ST_IDLE) && !timeout_c) ||
                  ((state_q == ST_LD_WRITE) && (state_d == ST_IDLE));
    err_d       = timeout_c;
    cnt_clr_c   = (state_q == ST_IDLE) && ((state_d == ST_RUN) || (state_d == ST_STEP_WAIT));
  end

  // Output registers; stop_debug only moves on posedge so the fetch negedge sees it stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_q      <= 1'b1;
      load_prog_q <= 1'b0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      stop_q      <= stop_d;
      load_prog_q <= load_prog_d;
      wr_q        <= wr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Word count, write address/data, rx idle timer and executed-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      idle_q     <= '0;
      cyc_q      <= '0;
    end else begin
      if ((state_q == ST_LD_CNT) && bus.rx_valid) word_cnt_q <= bus.rx_data;
      if ((state_q == ST_IDLE) && (state_d == ST_LD_CNT)) addr_q <= '0;
      else if (state_q == ST_LD_WRITE)                    addr_q <= addr_q + CNT_ADDR_W'(1);
      if (asm_ready_c) wr_data_q <= asm_word_c;
      if (!in_load_rx_c || bus.rx_valid || timeout_c) idle_q <= '0;
      else                                            idle_q <= idle_q + TO_W'(1);
      if (cnt_clr_c)                      cyc_q <= '0;
      else if (!stop_q && (cyc_q != '1))  cyc_q <= cyc_q + CNT_W'(1);
    end
  end

  assign wr_c = '{addr: ADDR_W'(addr_q), data: wr_data_q};

  assign bus.load_program   = load_prog_q;
  assign bus.wr_instruction = wr_q;
  assign bus.wr_addr        = wr_c.addr;
  assign bus.wr_data        = wr_c.data;
  assign bus.stop_debug     = stop_q;
  assign bus.load_done      = done_q;
  assign bus.load_error     = err_q;
  assign bus.state_o        = state_q;
  assign bus.cycle_count    = cyc_q;

endmodule

// File: tb/tb_fetch_debug_sequencer.sv
// Scoreboard bench for fetch_debug_sequencer: stimulus tasks push expected
// write/done/error/stall-window events with their cycle; a monitor pops them.
`timescale 1ns/1ps
module tb_fetch_debug_sequencer;
  import fetch_dbg_pkg::*;

  localparam int unsigned TO      = 16;
  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  typedef enum int {EV_WR = 0, EV_DONE = 1, EV_ERR = 2, EV_RUN = 3} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] addr;
    logic [31:0] data;
    int          t;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   t_last = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];
  logic [7:0] fixed_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_debug_sequencer_if #(.CNT_W(CW)) bus ();

  fetch_debug_sequencer #(.RX_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [31:0] a, input logic [31:0] d, input int t);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d addr 0x%08h data 0x%08h, expected none (cycle %0d)",
               k, a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind",  32'(k),   32'(e.kind));
      check("ev_addr",  a,        e.addr);
      check("ev_data",  d,        e.data);
      check("ev_cycle", 32'(cyc), 32'(e.t));
    end
  endtask

  // Monitor: sampled on negedge, away from the active edge.
  initial begin
    int low_len;
    low_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        low_len = 0;
      end else begin
        if (bus.wr_instruction) begin
          observe(EV_WR, bus.wr_addr, bus.wr_data);
          check("wr_with_load_program", 32'(bus.load_program), 32'd1);
        end
        if (bus.load_done)  observe(EV_DONE, 32'd0, 32'd0);
        if (bus.load_error) observe(EV_ERR, 32'd0, 32'd0);
        if (!bus.stop_debug) begin
          low_len++;
        end else if (low_len != 0) begin
          observe(EV_RUN, 32'd0, 32'(low_len));
          low_len = 0;
        end
      end
    end
  end

  // One strobe (byte and/or halt) held for exactly one clock, after gap idle cycles.
  task automatic send(input logic v, input logic [7:0] b, input logic h, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    bus.rx_valid      = v;
    bus.rx_data       = b;
    bus.halt_detected = h;
    @(posedge clk);
    #1;
    bus.rx_valid      = 1'b0;
    bus.halt_detected = 1'b0;
    bus.rx_data       = 8'($urandom);
    t_last = cyc;
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Load n words, sending nbytes data bytes (fewer than 4n ends in a timeout).
  task automatic do_load(input int n, input int nbytes);
    logic [7:0] b[4];
    logic [7:0] v;
    int         t_err;
    send(1'b1, CMD_LOAD, 1'b0, 2);
    check("load_state_cnt", 32'(bus.state_o), 32'd1);
    check("load_program_hi", 32'(bus.load_program), 32'd1);
    send(1'b1, 8'(n), 1'b0, $urandom_range(1, 3));
    if (n == 0) expect_ev(EV_DONE, 32'd0, 32'd0, t_last);
    for (int i = 0; i < nbytes; i++) begin
      v = (fixed_q.size() != 0) ? fixed_q.pop_front() : 8'($urandom);
      b[i % 4] = v;
      send(1'b1, v, 1'b0, $urandom_range(1, 3));
      if (i % 4 == 3) begin
        expect_ev(EV_WR, 32'(i / 4), {b[3], b[2], b[1], b[0]}, t_last);
        if (i / 4 == n - 1) expect_ev(EV_DONE, 32'd0, 32'd0, t_last + 1);
      end
    end
    if (nbytes < 4 * n) begin
      // The one-cycle write state is not part of the idle count.
      t_err = t_last + TO + (((nbytes % 4) == 0 && nbytes != 0) ? 1 : 0);
      expect_ev(EV_ERR, 32'd0, 32'd0, t_err);
    end
    drain(TO + 20);
    check("load_program_lo", 32'(bus.load_program), 32'd0);
    check("load_end_state", 32'(bus.state_o), 32'd0);
  endtask

  // Run, then stop after gap idle cycles by 'P' (mode 0), halt (1) or both (2).
  task automatic do_run(input int gap, input int mode);
    int tr, len;
    send(1'b1, CMD_RUN, 1'b0, 2);
    tr = t_last;
    check("run_stop_lo", 32'(bus.stop_debug), 32'd0);
    check("run_state", 32'(bus.state_o), 32'd4);
    case (mode)
      0:       send(1'b1, CMD_PAUSE, 1'b0, gap);
      1:       send(1'b0, 8'h00,     1'b1, gap);
      default: send(1'b1, CMD_PAUSE, 1'b1, gap);
    endcase
    len = t_last - tr;
    expect_ev(EV_RUN, 32'd0, 32'(len), t_last);
    check("run_stop_after_end", 32'(bus.stop_debug), 32'd1);
    check("run_end_state", 32'(bus.state_o), 32'd0);
    drain(8);
    check("run_cycle_count", 32'(bus.cycle_count), 32'((len > CNT_MAX) ? CNT_MAX : len));
  endtask

  task automatic do_step(input int n, input logic halt_end);
    send(1'b1, CMD_STEP, 1'b0, 2);
    check("step_wait_state", 32'(bus.state_o), 32'd5);
    check("step_wait_stop", 32'(bus.stop_debug), 32'd1);
    for (int i = 0; i < n; i++) begin
      send(1'b1, CMD_NEXT, 1'b0, $urandom_range(1, 3));
      expect_ev(EV_RUN, 32'd0, 32'd1, t_last + 1);
    end
    if (halt_end) send(1'b0, 8'h00, 1'b1, $urandom_range(1, 3));
    else          send(1'b1, CMD_EXIT, 1'b0, $urandom_range(1, 3));
    check("step_end_state", 32'(bus.state_o), 32'd0);
    drain(8);
    check("step_cycle_count", 32'(bus.cycle_count), 32'(n));
  endtask

  task automatic do_junk();
    logic [7:0] v;
    v = 8'($urandom);
    if (v == CMD_LOAD || v == CMD_RUN || v == CMD_STEP) v = 8'h00;
    send(1'b1, v, 1'b0, 2);
    check("junk_state", 32'(bus.state_o), 32'd0);
    check("junk_stop", 32'(bus.stop_debug), 32'd1);
    drain(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb;
    bus.rx_valid      = 1'b0;
    bus.rx_data       = 8'h00;
    bus.halt_detected = 1'b0;
    #12;
    check("rst_stop_debug",   32'(bus.stop_debug),     32'd1);
    check("rst_load_program", 32'(bus.load_program),   32'd0);
    check("rst_wr_instr",     32'(bus.wr_instruction), 32'd0);
    check("rst_wr_addr",      bus.wr_addr,             32'd0);
    check("rst_wr_data",      bus.wr_data,             32'd0);
    check("rst_load_done",    32'(bus.load_done),      32'd0);
    check("rst_load_error",   32'(bus.load_error),     32'd0);
    check("rst_state",        32'(bus.state_o),        32'd0);
    check("rst_cycle_count",  32'(bus.cycle_count),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_run(5, 0);
    fixed_q = '{8'h13, 8'h00, 8'h22, 8'h20, 8'h01, 8'h00, 8'h00, 8'hFC};
    do_load(2, 8);
    do_load(0, 0);
    do_load(3, 5);
    do_load(1, 4);
    do_step(2, 1'b0);
    do_run(3, 2);
    do_run(20, 1);
    do_step(1, 1'b1);

    // Asynchronous reset in the middle of a load.
    send(1'b1, CMD_LOAD, 1'b0, 2);
    send(1'b1, 8'd2, 1'b0, 1);
    send(1'b1, 8'hAA, 1'b0, 1);
    send(1'b1, 8'hBB, 1'b0, 1);
    check("midload_state", 32'(bus.state_o), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_stop_debug",   32'(bus.stop_debug),     32'd1);
    check("midrst_load_program", 32'(bus.load_program),   32'd0);
    check("midrst_wr_instr",     32'(bus.wr_instruction), 32'd0);
    check("midrst_state",        32'(bus.state_o),        32'd0);
    check("midrst_wr_addr",      bus.wr_addr,             32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          n  = $urandom_range(0, 4);
          nb = 4 * n;
          if (n != 0 && $urandom_range(0, 3) == 0) nb = $urandom_range(0, 4 * n - 1);
          do_load(n, nb);
        end
        1: do_run($urandom_range(0, 20), $urandom_range(0, 2));
        2: do_step($urandom_range(0, 4), 1'($urandom_range(0, 1)));
        default: do_junk();
      endcase
    end

    repeat (4) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
